// File: rtl/spart_drv_pkg.sv
// spart_drv_pkg: shared states, SPART register addresses and baud divisors for spart_driver
package spart_drv_pkg;

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      IDLE,
      RX_READ,
      TX_WRITE
   } state_t;

   localparam logic [1:0] ADDR_BUF    = 2'b00;
   localparam logic [1:0] ADDR_STAT   = 2'b01;
   localparam logic [1:0] ADDR_DIV_LO = 2'b10;
   localparam logic [1:0] ADDR_DIV_HI = 2'b11;

   localparam logic [15:0] DIV_4800  = 16'h5161;
   localparam logic [15:0] DIV_9600  = 16'h28B1;
   localparam logic [15:0] DIV_19200 = 16'h1458;
   localparam logic [15:0] DIV_38400 = 16'h0A2C;

   function automatic logic [15:0] divisor(input logic [1:0] br);
      return br == 2'd0 ? DIV_4800 :
             br == 2'd1 ? DIV_9600 :
             br == 2'd2 ? DIV_19200 : DIV_38400;
   endfunction

endpackage

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor, then moves bytes between host and SPART.
// Build option SPART_DRV_RECONFIG_EN: a br_cfg change seen in IDLE re-runs configuration.
module spart_driver
   import spart_drv_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   input  logic       rda,
   input  logic       tbr,
   input  logic       tx_req,
   input  logic [7:0] tx_data,
   output logic       tx_ack,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       cfg_done
);

   state_t      state_q, state_d;
   logic [1:0]  br_q, br_d;
   logic        iocs_q, iocs_d;
   logic        iorw_q, iorw_d;
   logic [1:0]  ioaddr_q, ioaddr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        tx_ack_q, tx_ack_d;
   logic        cfg_done_q, cfg_done_d;
   logic        rx_valid_q;
   logic [7:0]  rx_byte_q;
   logic [15:0] div_new, div_cur;

   // The bus stage is registered: the cycle that decides an access loads it, and
   // the access is on the pins for exactly the following cycle, which is the cycle
   // spent in the matching state. CFG_LO is entered with iocs low, so its first
   // cycle samples br_cfg and issues the low write; its second cycle is that write.
   assign div_new = divisor(br_cfg);
   assign div_cur = divisor(br_q);

   // Next-state and next bus-access decode
   always_comb begin
      state_d    = state_q;
      br_d       = br_q;
      iocs_d     = 1'b0;
      iorw_d     = 1'b1;
      ioaddr_d   = ADDR_BUF;
      wdata_d    = wdata_q;
      tx_ack_d   = 1'b0;
      cfg_done_d = cfg_done_q;
      case (state_q)
         CFG_LO: begin
            iocs_d = 1'b1;
            iorw_d = 1'b0;
            if (!iocs_q) begin
               br_d     = br_cfg;
               ioaddr_d = ADDR_DIV_LO;
               wdata_d  = div_new[7:0];
            end else begin
               state_d  = CFG_HI;
               ioaddr_d = ADDR_DIV_HI;
               wdata_d  = div_cur[15:8];
            end
         end
         CFG_HI: begin
            state_d    = IDLE;
            cfg_done_d = 1'b1;
         end
         IDLE: begin
            if (rda) begin
               state_d = RX_READ;
               iocs_d  = 1'b1;
            end
`ifdef SPART_DRV_RECONFIG_EN
            else if (br_cfg != br_q) begin
               state_d    = CFG_LO;
               cfg_done_d = 1'b0;
            end
`endif
            else if (tx_req && tbr) begin
               state_d  = TX_WRITE;
               iocs_d   = 1'b1;
               iorw_d   = 1'b0;
               wdata_d  = tx_data;
               tx_ack_d = 1'b1;
            end
         end
         RX_READ:  state_d = IDLE;
         TX_WRITE: state_d = IDLE;
         default:  state_d = CFG_LO;
      endcase
   end

   // State, latched baud select and configuration flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CFG_LO;
         br_q       <= 2'd0;
         cfg_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         br_q       <= br_d;
         cfg_done_q <= cfg_done_d;
      end
   end

   // Registered bus-output stage; reset drops any access in flight at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iocs_q   <= 1'b0;
         iorw_q   <= 1'b1;
         ioaddr_q <= ADDR_BUF;
         wdata_q  <= 8'h00;
         tx_ack_q <= 1'b0;
      end else begin
         iocs_q   <= iocs_d;
         iorw_q   <= iorw_d;
         ioaddr_q <= ioaddr_d;
         wdata_q  <= wdata_d;
         tx_ack_q <= tx_ack_d;
      end
   end

   // Capture read data at the end of the read cycle and flag it the cycle after
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_byte_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= state_q == RX_READ;
         if (state_q == RX_READ) rx_byte_q <= databus;
      end
   end

   assign databus  = (iocs_q && !iorw_q) ? wdata_q : 8'hzz;
   assign iocs     = iocs_q;
   assign iorw     = iorw_q;
   assign ioaddr   = ioaddr_q;
   assign tx_ack   = tx_ack_q;
   assign rx_byte  = rx_byte_q;
   assign rx_valid = rx_valid_q;
   assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: scoreboard bench for spart_driver; expected bus accesses and received bytes are queued by the stimulus and consumed by a monitor
module tb_spart_driver;

   typedef struct {
      logic       rw;
      logic [1:0] a;
      logic [7:0] d;
   } acc_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] br_cfg = 2'd1;
   logic       iocs, iorw, tx_ack, rx_valid, cfg_done;
   logic [1:0] ioaddr;
   wire  [7:0] databus;
   logic       rda = 1'b0, tbr = 1'b0, tx_req = 1'b0;
   logic [7:0] tx_data = 8'h00, rx_byte, spart_rd = 8'h00;

   acc_t       exp_q[$];
   logic [7:0] rx_q[$];
   int         n_chk = 0, n_pass = 0, acks = 0, rxs = 0;

   assign databus = (iocs && iorw) ? spart_rd : 8'hzz;

   spart_driver dut (
      .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .databus(databus), .rda(rda), .tbr(tbr), .tx_req(tx_req), .tx_data(tx_data),
      .tx_ack(tx_ack), .rx_byte(rx_byte), .rx_valid(rx_valid), .cfg_done(cfg_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got=%h want=%h", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic rw, input logic [1:0] a, input logic [7:0] d);
      acc_t e;
      e.rw = rw; e.a = a; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(input string nm);
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (tx_ack) return;
      end
      n_chk++;
      $display("FAIL %s got=no_tx_ack want=tx_ack within 30 cycles", nm);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (iocs) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_access got=rw%0d addr%0d data%h want=no access", iorw, ioaddr, databus);
            end else begin
               acc_t e;
               e = exp_q.pop_front();
               chk("bus_access", {21'd0, iorw, ioaddr, databus}, {21'd0, e.rw, e.a, e.d});
            end
         end
         if (tx_ack) begin
            acks++;
            chk("tx_ack_with_write", {28'd0, iocs, iorw, ioaddr}, 32'h8);
         end
         if (rx_valid) begin
            rxs++;
            if (rx_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_rx_valid got=%h want=no pulse", rx_byte);
            end else chk("rx_byte", {24'd0, rx_byte}, {24'd0, rx_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(2);
      chk("rst_iocs", {31'd0, iocs}, 32'd0);
      chk("rst_iorw", {31'd0, iorw}, 32'd1);
      chk("rst_ioaddr", {30'd0, ioaddr}, 32'd0);
      chk("rst_tx_ack", {31'd0, tx_ack}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
      chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
      push(1'b0, 2'b10, 8'hB1);
      push(1'b0, 2'b11, 8'h28);
      rst = 1'b0;
      tick(2);
      chk("cfg_done_early", {31'd0, cfg_done}, 32'd0);
      tick(1);
      chk("cfg_done_set", {31'd0, cfg_done}, 32'd1);
      chk("cfg_writes_done", exp_q.size(), 32'd0);
      tick(2);
      spart_rd = 8'h5A;
      push(1'b1, 2'b00, 8'h5A);
      rx_q.push_back(8'h5A);
      rda = 1'b1;
      tick(1);
      rda = 1'b0;
      tick(4);
      chk("rx_byte_held", {24'd0, rx_byte}, 32'h5A);
      tx_req = 1'b1; tx_data = 8'hC3; tbr = 1'b0;
      tick(10);
      chk("no_ack_tbr_low", acks, 32'd0);
      push(1'b0, 2'b00, 8'hC3);
      tbr = 1'b1;
      wait_ack("tx_c3");
      tx_req = 1'b0;
      tick(3);
      spart_rd = 8'hA5;
      push(1'b1, 2'b00, 8'hA5);
      push(1'b0, 2'b00, 8'h3C);
      rx_q.push_back(8'hA5);
      rda = 1'b1; tx_req = 1'b1; tx_data = 8'h3C;
      tick(1);
      rda = 1'b0;
      wait_ack("tx_3c");
      tx_req = 1'b0;
      tick(3);
      chk("prio_queue_empty", exp_q.size(), 32'd0);
      tx_req = 1'b1; tx_data = 8'h77;
      wait_ack("tx_77");
      rst = 1'b1;
      tx_req = 1'b0;
      #1;
      chk("abort_iocs", {31'd0, iocs}, 32'd0);
      chk("abort_iorw", {31'd0, iorw}, 32'd1);
      chk("abort_tx_ack", {31'd0, tx_ack}, 32'd0);
      chk("abort_cfg_done", {31'd0, cfg_done}, 32'd0);
      tick(1);
      push(1'b0, 2'b10, 8'hB1);
      push(1'b0, 2'b11, 8'h28);
      rst = 1'b0;
      tick(3);
      chk("recfg_done", {31'd0, cfg_done}, 32'd1);
      chk("recfg_writes", exp_q.size(), 32'd0);
      tick(2);
`ifdef SPART_DRV_RECONFIG_EN
      push(1'b0, 2'b10, 8'h2C);
      push(1'b0, 2'b11, 8'h0A);
      br_cfg = 2'd3;
      tick(1);
      chk("brchg_cfg_cleared", {31'd0, cfg_done}, 32'd0);
`else
      br_cfg = 2'd3;
      tick(1);
      chk("brchg_cfg_kept", {31'd0, cfg_done}, 32'd1);
`endif
      tick(10);
      chk("brchg_cfg_done", {31'd0, cfg_done}, 32'd1);
      chk("final_bus_queue", exp_q.size(), 32'd0);
      chk("final_rx_queue", rx_q.size(), 32'd0);
      chk("tx_ack_count", acks, 32'd2);
      chk("rx_valid_count", rxs, 32'd2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
